// File: rtl/escalonador_pkg.sv
// Shared types for the round-robin process scheduler: slot states,
// scheduler FSM states, latched switch-event encoding and the default
// address of the OS idle loop.
package escalonador_pkg;

    // Lifecycle of one process-table slot. DONE is transient: a finished
    // process is released to FREE in the same cycle it is saved.
    typedef enum logic [2:0] {
        SLOT_FREE    = 3'd0,
        SLOT_READY   = 3'd1,
        SLOT_RUNNING = 3'd2,
        SLOT_BLOCKED = 3'd3,
        SLOT_DONE    = 3'd4
    } slot_state_t;

    // Scheduler control states.
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SAVE   = 2'd1,
        ST_SELECT = 2'd2,
        ST_WAIT   = 2'd3
    } fsm_state_t;

    // Switch event captured in RUN and consumed in SAVE.
    typedef enum logic [1:0] {
        EV_NONE  = 2'd0,
        EV_FIM   = 2'd1,
        EV_IO    = 2'd2,
        EV_TROCA = 2'd3
    } evento_t;

    // PC of the OS idle loop when no process is runnable.
    localparam logic [31:0] SO_BASE_DEFAULT = 32'd0;

endpackage

// File: rtl/escalonador_processos_rr_seletor.sv
// Combinational round-robin picker: rotates the ready vector so the
// start index lands at bit 0, then takes the lowest set bit.
module rr_seletor #(
    parameter int N_PROC = 4,
    parameter int PID_W  = $clog2(N_PROC)
) (
    input  logic [N_PROC-1:0] i_pronto,
    input  logic [PID_W-1:0]  i_inicio,
    output logic              o_achou,
    output logic [PID_W-1:0]  o_vencedor
);

    logic [N_PROC-1:0] w_rotacionado;
    logic [PID_W-1:0]  w_deslocamento;

    // Bit gi of the rotated vector is slot (start + gi) mod N_PROC; the
    // PID_W-bit add wraps naturally because N_PROC is a power of two.
    for (genvar gi = 0; gi < N_PROC; gi++) begin : g_rot
        logic [PID_W-1:0] w_idx;
        assign w_idx             = i_inicio + PID_W'(gi);
        assign w_rotacionado[gi] = i_pronto[w_idx];
    end

    // Lowest set bit of the rotated vector is the nearest ready slot.
    always_comb begin
        o_achou        = 1'b0;
        w_deslocamento = '0;
        for (int i = N_PROC - 1; i >= 0; i--) begin
            if (w_rotacionado[i]) begin
                o_achou        = 1'b1;
                w_deslocamento = PID_W'(i);
            end
        end
    end

    assign o_vencedor = i_inicio + w_deslocamento;

endmodule

// File: rtl/escalonador_processos.sv
// Round-robin process scheduler: owns the process table, saves the
// outgoing PC on a switch event, dispatches the next READY slot with a
// one-cycle pc_load and parks the core in the OS idle loop when idle.
module escalonador_processos
    import escalonador_pkg::*;
#(
    parameter int          N_PROC  = 4,
    parameter int          PID_W   = $clog2(N_PROC),
    parameter logic [31:0] SO_BASE = SO_BASE_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             troca_contexto,
    input  logic             instrucao_io,
    input  logic             fim_processo,
    input  logic [31:0]      pc_processo_trocado,
    input  logic             cria_processo,
    input  logic [31:0]      pc_inicial,
    input  logic             io_concluido,
    input  logic [PID_W-1:0] io_pid,
    output logic             pc_load,
    output logic [31:0]      pc_destino,
    output logic [PID_W-1:0] processo_atual,
    output logic             ocioso,
    output logic             ocupado,
    output logic             cria_ack,
    output logic             cria_erro
);

    slot_state_t       r_estado [N_PROC];
    logic [31:0]       r_pc     [N_PROC];
    fsm_state_t        r_fsm;
    evento_t           r_evento;
    logic [31:0]       r_pc_trocado;
    logic              r_pc_load;
    logic [31:0]       r_pc_destino;
    logic [PID_W-1:0]  r_processo_atual;
    logic              r_ocioso;
    logic              r_ocupado;
    logic              r_cria_ack;
    logic              r_cria_erro;

    logic [N_PROC-1:0] w_pronto;
    logic [N_PROC-1:0] w_livre;
    logic              w_achou;
    logic [PID_W-1:0]  w_vencedor;
    logic              w_livre_achou;
    logic [PID_W-1:0]  w_livre_idx;
    logic [PID_W-1:0]  w_inicio;

    for (genvar gi = 0; gi < N_PROC; gi++) begin : g_status
        assign w_pronto[gi] = (r_estado[gi] == SLOT_READY);
        assign w_livre[gi]  = (r_estado[gi] == SLOT_FREE);
    end

    // Search begins just after the last dispatched slot and ends on it.
    assign w_inicio = r_processo_atual + PID_W'(1);

    rr_seletor #(
        .N_PROC (N_PROC),
        .PID_W  (PID_W)
    ) u_rr_seletor (
        .i_pronto   (w_pronto),
        .i_inicio   (w_inicio),
        .o_achou    (w_achou),
        .o_vencedor (w_vencedor)
    );

    // Lowest-index FREE slot receives a newly created process.
    always_comb begin
        w_livre_achou = 1'b0;
        w_livre_idx   = '0;
        for (int i = N_PROC - 1; i >= 0; i--) begin
            if (w_livre[i]) begin
                w_livre_achou = 1'b1;
                w_livre_idx   = PID_W'(i);
            end
        end
    end

    // Process table: I/O wake-up, SAVE write-back, dispatch mark, create.
    // The writers never collide: each targets a slot in a distinct state.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N_PROC; i++) begin
                r_estado[i] <= SLOT_FREE;
                r_pc[i]     <= '0;
            end
            r_cria_ack  <= 1'b0;
            r_cria_erro <= 1'b0;
        end else begin
            r_cria_ack  <= 1'b0;
            r_cria_erro <= 1'b0;
            if (io_concluido && r_estado[io_pid] == SLOT_BLOCKED) begin
                r_estado[io_pid] <= SLOT_READY;
            end
            if (r_fsm == ST_SAVE) begin
                case (r_evento)
                    EV_FIM: begin
                        r_estado[r_processo_atual] <= SLOT_FREE;
                    end
                    EV_IO: begin
                        r_estado[r_processo_atual] <= SLOT_BLOCKED;
                        r_pc[r_processo_atual]     <= r_pc_trocado;
                    end
                    EV_TROCA: begin
                        r_estado[r_processo_atual] <= SLOT_READY;
                        r_pc[r_processo_atual]     <= r_pc_trocado;
                    end
                    default: ;
                endcase
            end
            if (r_fsm == ST_SELECT && w_achou) begin
                r_estado[w_vencedor] <= SLOT_RUNNING;
            end
            if (cria_processo) begin
                if (w_livre_achou) begin
                    r_estado[w_livre_idx] <= SLOT_READY;
                    r_pc[w_livre_idx]     <= pc_inicial;
                    r_cria_ack            <= 1'b1;
                end else begin
                    r_cria_erro <= 1'b1;
                end
            end
        end
    end

    // Scheduler FSM with registered dispatch outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_fsm            <= ST_WAIT;
            r_evento         <= EV_NONE;
            r_pc_trocado     <= '0;
            r_pc_load        <= 1'b0;
            r_pc_destino     <= '0;
            r_processo_atual <= '0;
            r_ocioso         <= 1'b1;
            r_ocupado        <= 1'b0;
        end else begin
            r_pc_load <= 1'b0;
            case (r_fsm)
                ST_RUN: begin
                    if (fim_processo || instrucao_io || troca_contexto) begin
                        r_fsm        <= ST_SAVE;
                        r_ocupado    <= 1'b1;
                        r_pc_trocado <= pc_processo_trocado;
                        if (fim_processo) begin
                            r_evento <= EV_FIM;
                        end else if (instrucao_io) begin
                            r_evento <= EV_IO;
                        end else begin
                            r_evento <= EV_TROCA;
                        end
                    end
                end
                ST_SAVE: begin
                    r_fsm <= ST_SELECT;
                end
                ST_SELECT: begin
                    r_ocupado <= 1'b0;
                    r_pc_load <= 1'b1;
                    r_evento  <= EV_NONE;
                    if (w_achou) begin
                        r_pc_destino     <= r_pc[w_vencedor];
                        r_processo_atual <= w_vencedor;
                        r_ocioso         <= 1'b0;
                        r_fsm            <= ST_RUN;
                    end else begin
                        r_pc_destino <= SO_BASE;
                        r_ocioso     <= 1'b1;
                        r_fsm        <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (|w_pronto) begin
                        r_fsm     <= ST_SELECT;
                        r_ocupado <= 1'b1;
                    end
                end
                default: begin
                    r_fsm <= ST_WAIT;
                end
            endcase
        end
    end

    assign pc_load        = r_pc_load;
    assign pc_destino     = r_pc_destino;
    assign processo_atual = r_processo_atual;
    assign ocioso         = r_ocioso;
    assign ocupado        = r_ocupado;
    assign cria_ack       = r_cria_ack;
    assign cria_erro      = r_cria_erro;

endmodule

// File: tb/tb_escalonador_processos.sv
// Directed bench for the round-robin scheduler with hand-computed values.
module tb_escalonador_processos;

    logic        clock = 1'b0;
    logic        reset;
    logic        troca_contexto;
    logic        instrucao_io;
    logic        fim_processo;
    logic [31:0] pc_processo_trocado;
    logic        cria_processo;
    logic [31:0] pc_inicial;
    logic        io_concluido;
    logic [1:0]  io_pid;
    logic        pc_load;
    logic [31:0] pc_destino;
    logic [1:0]  processo_atual;
    logic        ocioso;
    logic        ocupado;
    logic        cria_ack;
    logic        cria_erro;

    int n_pass  = 0;
    int n_total = 0;

    escalonador_processos #(
        .N_PROC  (4),
        .PID_W   (2),
        .SO_BASE (32'd0)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .troca_contexto      (troca_contexto),
        .instrucao_io        (instrucao_io),
        .fim_processo        (fim_processo),
        .pc_processo_trocado (pc_processo_trocado),
        .cria_processo       (cria_processo),
        .pc_inicial          (pc_inicial),
        .io_concluido        (io_concluido),
        .io_pid              (io_pid),
        .pc_load             (pc_load),
        .pc_destino          (pc_destino),
        .processo_atual      (processo_atual),
        .ocioso              (ocioso),
        .ocupado             (ocupado),
        .cria_ack            (cria_ack),
        .cria_erro           (cria_erro)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Create one process; ack (or error) is checked the cycle after.
    task automatic criar(input logic [31:0] pc, input logic exp_ack);
        cria_processo = 1'b1;
        pc_inicial    = pc;
        tick();
        cria_processo = 1'b0;
        $display("create pc=%0d ack=%0b erro=%0b", pc, cria_ack, cria_erro);
        chk("cria_ack", cria_ack, exp_ack);
        chk("cria_erro", cria_erro, !exp_ack);
    endtask

    // One switch event from RUN: pc_load must appear on the third edge only.
    task automatic evento(input logic fim, input logic io, input logic troca,
                          input logic [31:0] pc, input logic [31:0] exp_dest,
                          input logic [1:0] exp_atual, input logic exp_ocioso);
        fim_processo        = fim;
        instrucao_io        = io;
        troca_contexto      = troca;
        pc_processo_trocado = pc;
        tick();
        fim_processo   = 1'b0;
        instrucao_io   = 1'b0;
        troca_contexto = 1'b0;
        chk("save_ocupado", ocupado, 1'b1);
        chk("save_pc_load", pc_load, 1'b0);
        tick();
        chk("select_pc_load", pc_load, 1'b0);
        tick();
        $display("event fim=%0b io=%0b troca=%0b pc=%0d -> load=%0b dest=%0d atual=%0d ocioso=%0b",
                 fim, io, troca, pc, pc_load, pc_destino, processo_atual, ocioso);
        chk("dispatch_pc_load", pc_load, 1'b1);
        chk("dispatch_dest", pc_destino, exp_dest);
        chk("dispatch_atual", {30'd0, processo_atual}, {30'd0, exp_atual});
        chk("dispatch_ocioso", ocioso, exp_ocioso);
        chk("dispatch_ocupado", ocupado, 1'b0);
        tick();
        chk("load_one_cycle", pc_load, 1'b0);
        chk("dest_held", pc_destino, exp_dest);
    endtask

    // Dispatch from WAIT: READY visible after the create edge, load two edges later.
    task automatic espera_despacho(input logic [31:0] exp_dest, input logic [1:0] exp_atual);
        tick();
        chk("wait_pc_load_early", pc_load, 1'b0);
        tick();
        $display("wait dispatch -> load=%0b dest=%0d atual=%0d ocioso=%0b",
                 pc_load, pc_destino, processo_atual, ocioso);
        chk("wait_pc_load", pc_load, 1'b1);
        chk("wait_dest", pc_destino, exp_dest);
        chk("wait_atual", {30'd0, processo_atual}, {30'd0, exp_atual});
        chk("wait_ocioso", ocioso, 1'b0);
        tick();
        chk("wait_load_one_cycle", pc_load, 1'b0);
    endtask

    initial begin
        reset               = 1'b1;
        troca_contexto      = 1'b0;
        instrucao_io        = 1'b0;
        fim_processo        = 1'b0;
        pc_processo_trocado = '0;
        cria_processo       = 1'b0;
        pc_inicial          = '0;
        io_concluido        = 1'b0;
        io_pid              = '0;
        tick();
        tick();
        $display("reset load=%0b dest=%0d atual=%0d ocioso=%0b ocupado=%0b",
                 pc_load, pc_destino, processo_atual, ocioso, ocupado);
        chk("rst_pc_load", pc_load, 1'b0);
        chk("rst_dest", pc_destino, 32'd0);
        chk("rst_atual", {30'd0, processo_atual}, 32'd0);
        chk("rst_ocioso", ocioso, 1'b1);
        chk("rst_ocupado", ocupado, 1'b0);
        chk("rst_ack", cria_ack, 1'b0);
        chk("rst_erro", cria_erro, 1'b0);
        reset = 1'b0;

        // First process from idle.
        criar(32'd400, 1'b1);
        espera_despacho(32'd400, 2'd0);

        // Round robin through slots 0,1,2; slot 0 must resume at its saved 405.
        criar(32'd500, 1'b1);
        criar(32'd600, 1'b1);
        evento(1'b0, 1'b0, 1'b1, 32'd405, 32'd500, 2'd1, 1'b0);
        evento(1'b0, 1'b0, 1'b1, 32'd505, 32'd600, 2'd2, 1'b0);
        evento(1'b0, 1'b0, 1'b1, 32'd605, 32'd405, 2'd0, 1'b0);

        // Single process blocks on I/O: idle loop, events ignored, wake-up resumes.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        criar(32'd400, 1'b1);
        espera_despacho(32'd400, 2'd0);
        evento(1'b0, 1'b1, 1'b0, 32'd410, 32'd0, 2'd0, 1'b1);
        troca_contexto = 1'b1;
        tick();
        troca_contexto = 1'b0;
        chk("wait_ignores_event", ocupado, 1'b0);
        tick();
        tick();
        chk("wait_no_load", pc_load, 1'b0);
        io_concluido = 1'b1;
        io_pid       = 2'd0;
        tick();
        io_concluido = 1'b0;
        espera_despacho(32'd410, 2'd0);

        // fim_processo beats troca_contexto: slot freed, next create reuses slot 0.
        evento(1'b1, 1'b0, 1'b1, 32'd999, 32'd0, 2'd0, 1'b1);
        criar(32'd700, 1'b1);
        espera_despacho(32'd700, 2'd0);

        // Fill the table, reject a fifth create, ignore io_concluido on a non-blocked slot.
        criar(32'd800, 1'b1);
        criar(32'd900, 1'b1);
        criar(32'd1000, 1'b1);
        criar(32'd1100, 1'b0);
        io_concluido = 1'b1;
        io_pid       = 2'd2;
        tick();
        io_concluido = 1'b0;
        chk("io_ready_no_effect_load", pc_load, 1'b0);
        chk("io_ready_no_effect_busy", ocupado, 1'b0);
        evento(1'b0, 1'b0, 1'b1, 32'd705, 32'd800, 2'd1, 1'b0);
        evento(1'b0, 1'b0, 1'b1, 32'd805, 32'd900, 2'd2, 1'b0);
        evento(1'b0, 1'b0, 1'b1, 32'd905, 32'd1000, 2'd3, 1'b0);
        evento(1'b0, 1'b0, 1'b1, 32'd1005, 32'd705, 2'd0, 1'b0);

        // Reset in SELECT abandons the switch and empties the table.
        troca_contexto      = 1'b1;
        pc_processo_trocado = 32'd710;
        tick();
        troca_contexto = 1'b0;
        tick();
        chk("select_ocupado", ocupado, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        $display("reset in select -> load=%0b dest=%0d ocioso=%0b", pc_load, pc_destino, ocioso);
        chk("abort_pc_load", pc_load, 1'b0);
        chk("abort_ocioso", ocioso, 1'b1);
        chk("abort_ocupado", ocupado, 1'b0);
        chk("abort_dest", pc_destino, 32'd0);
        chk("abort_atual", {30'd0, processo_atual}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_table_empty", pc_load, 1'b0);
        end
        criar(32'd1200, 1'b1);
        espera_despacho(32'd1200, 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/escalonador_processos.md
# escalonador_processos

Round-robin process scheduler for the multiprogrammed processor. It owns the process table: a state and a saved PC per slot. It reacts to the quantum counter's context-switch, I/O and end-of-process signals by saving the outgoing PC, picking the next READY process, and issuing a one-cycle PC load to the fetch stage. When nothing is runnable, it parks the core in the OS idle loop.

## Interface
Parameters:
- N_PROC, 4: number of process slots (power of two, 2..16).
- PID_W, $clog2(N_PROC): process-id width.
- SO_BASE, 32'd0: PC of the OS idle loop, loaded when no process is READY.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- troca_contexto  in  1  quantum expired for the running process.
- instrucao_io  in  1  running process issued I/O and must block.
- fim_processo  in  1  running process finished.
- pc_processo_trocado  in  32  PC to resume the outgoing process at.
- cria_processo  in  1  request to create a process.
- pc_inicial  in  32  start PC for the created process.
- io_concluido  in  1  I/O completion strobe.
- io_pid  in  PID_W  slot whose I/O completed.
- pc_load  out  1  one-cycle strobe: fetch must load pc_destino.
- pc_destino  out  32  PC to load.
- processo_atual  out  PID_W  slot currently RUNNING.
- ocioso  out  1  no process running; core is in the OS idle loop.
- ocupado  out  1  switch in progress; events are ignored.
- cria_ack  out  1  one-cycle pulse: create accepted.
- cria_erro  out  1  one-cycle pulse: create rejected because the table is full.

## Operation
- Slot states are FREE, READY, RUNNING, BLOCKED and DONE. DONE returns to FREE in the same SAVE cycle.
- The FSM has four states: RUN, SAVE, SELECT, WAIT.
- RUN:
  - Samples the switch events.
  - Priority: fim_processo > instrucao_io > troca_contexto.
  - Any event moves the FSM to SAVE and latches the event type and pc_processo_trocado.
- SAVE writes the outgoing slot:
  - fim_processo: slot becomes FREE.
  - instrucao_io: slot becomes BLOCKED, saved PC is written.
  - troca_contexto: slot becomes READY, saved PC is written.
  - Next state is SELECT.
- SELECT:
  - Round-robin search starts at processo_atual+1, wraps modulo N_PROC, and ends at processo_atual inclusive.
  - A winner is found: mark it RUNNING, drive pc_destino with its saved PC, pulse pc_load, set processo_atual, go to RUN.
  - No winner: drive pc_destino=SO_BASE, pulse pc_load, set ocioso=1, go to WAIT.
- WAIT:
  - Switch events are ignored.
  - When any slot is READY, go to SELECT. The search starts at the last processo_atual+1.
  - ocioso clears when SELECT dispatches.
- ocupado=1 in SAVE and SELECT. Switch events arriving then are dropped.
- Create is accepted in every FSM state:
  - The lowest-index FREE slot is written with pc_inicial and becomes READY; cria_ack pulses the next cycle.
  - No FREE slot: cria_erro pulses the next cycle and the table is unchanged.
  - FREE status is evaluated before the same-cycle SAVE write.
- io_concluido: if slot io_pid is BLOCKED it becomes READY; in any other state the strobe is ignored. Takes effect in the cycle it is sampled.
- All PC arithmetic is 32-bit with no adjustment. The scheduler never adds to a PC.

## Timing
- Reset values:
  - FSM in WAIT, all slots FREE, saved PCs 0.
  - pc_load=0, pc_destino=0, processo_atual=0, ocioso=1, ocupado=0, cria_ack=0, cria_erro=0.
- An event sampled at edge N gives SAVE at N+1, SELECT at N+2, and pc_load=1 for exactly cycle N+3 (registered output). Latency is fixed at 3 cycles.
- WAIT to dispatch: a READY slot visible at edge M gives pc_load at M+2.
- pc_destino holds its value after pc_load falls.
- Reset during SAVE or SELECT abandons the switch. No pc_load is issued and all reset values apply on the next cycle.

## Structure
- Package escalonador_pkg:
  - slot-state enum (FREE, READY, RUNNING, BLOCKED, DONE);
  - FSM-state enum;
  - event-type encoding;
  - default SO_BASE.
- Sub-module rr_seletor is purely combinational:
  - inputs: N_PROC-bit ready vector and start index;
  - outputs: found flag and winner PID, via a rotate-then-priority-encode.

## Test plan
- Reset, then create with pc_inicial=400: cria_ack=1 next cycle; after 2 more cycles pc_load=1, pc_destino=400, processo_atual=0, ocioso=0.
- Slots 0, 1, 2 READY at PCs 400/500/600, slot 0 running. Pulse troca_contexto with pc_processo_trocado=405: 3 cycles later pc_load with pc_destino=500, processo_atual=1. Slot 0 saved PC reads 405.
- Only slot 0 exists, instrucao_io with PC 410: pc_load with pc_destino=0, ocioso=1. Then io_concluido with io_pid=0: 2 cycles later pc_load with pc_destino=410.
- fim_processo and troca_contexto in the same cycle: slot becomes FREE, not READY. A subsequent create reuses slot 0.
- Four slots filled, fifth create: cria_erro=1, no table change. io_concluido on a READY slot: no effect.
- Reset asserted in the SELECT cycle: no pc_load. Next cycle ocioso=1, all slots FREE.
